// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        FETCH_AR = 2'd0,
        FETCH_R  = 2'd1,
        SEND     = 2'd2,
        WAIT_PC  = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam logic [31:0] DEF_RESET_PC   = 32'h8000_0000;
    localparam logic [31:0] DEF_FAULT_INST = 32'h0010_0073;  // ebreak

    // Word-aligned fetch address for a given pc.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch-side bundle: AXI4-Lite AR/R channels plus the decode handshake.
interface ifu_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        ifu_send_valid;
    logic        ifu_receive_ready;
    logic [31:0] pc_next;
    logic        pc_write_enable;
    logic        fetch_fault;

    // IFU side
    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid,
        output instruction, pc, ifu_send_valid, fetch_fault,
        input  ifu_receive_ready, pc_next, pc_write_enable
    );

    // Memory / decode side
    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid,
        input  instruction, pc, ifu_send_valid, fetch_fault,
        output ifu_receive_ready, pc_next, pc_write_enable
    );
endinterface

// File: rtl/ifu_perf_cnt.sv
// Fetch performance counters: completed reads and fetch-stall cycles.
// Both are free-running and wrap at 2^32.
module ifu_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_done,
    input  logic        stall,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    // Count R handshakes and stalled fetch cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fetch_done) fetch_cnt <= fetch_cnt + 32'd1;
            if (stall)      stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one AXI4-Lite read per instruction, one in flight.
// Optional perf counters enabled by defining YSYX_23060059_IFU_PERF_EN.
//
// state    | meaning
// FETCH_AR | address phase, arvalid held until arready
// FETCH_R  | data phase, rready held until rvalid
// SEND     | instruction/pc offered to decode
// WAIT_PC  | decode accepted, waiting for pc_next
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] FAULT_INST = DEF_FAULT_INST
) (
    input  logic        clk,
    input  logic        rst,
    ifu_if.master       bus
`ifdef YSYX_23060059_IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    ifu_state_e  state, state_next;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        fault_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        send_valid_q;
    logic        pc_load;
    logic        ar_hs;
    logic        r_hs;
    logic        send_hs;
    logic        r_fault;

    assign ar_hs   = arvalid_q && bus.arready;
    assign r_hs    = rready_q && bus.rvalid;
    assign send_hs = send_valid_q && bus.ifu_receive_ready;
    assign r_fault = (bus.rresp != RESP_OKAY) || (pc_q[1:0] != 2'b00);

    assign bus.araddr         = align_word(pc_q);
    assign bus.arvalid        = arvalid_q;
    assign bus.rready         = rready_q;
    assign bus.instruction    = inst_q;
    assign bus.pc             = pc_q;
    assign bus.ifu_send_valid = send_valid_q;
    assign bus.fetch_fault    = fault_q;

    // Next-state and pc-load decode; pc_write_enable only matters once decode has the instruction.
    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        case (state)
            FETCH_AR: if (ar_hs) state_next = FETCH_R;
            FETCH_R:  if (r_hs)  state_next = SEND;
            SEND: begin
                if (send_hs) begin
                    if (bus.pc_write_enable) begin
                        pc_load    = 1'b1;
                        state_next = FETCH_AR;
                    end else begin
                        state_next = WAIT_PC;
                    end
                end
            end
            WAIT_PC: begin
                if (bus.pc_write_enable) begin
                    pc_load    = 1'b1;
                    state_next = FETCH_AR;
                end
            end
            default: state_next = FETCH_AR;
        endcase
    end

    // State, pc and registered handshake outputs; outputs follow the next state so
    // reset can hold them low while the first fetch still starts one edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= FETCH_AR;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            fault_q      <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            send_valid_q <= 1'b0;
        end else begin
            state        <= state_next;
            arvalid_q    <= (state_next == FETCH_AR);
            rready_q     <= (state_next == FETCH_R);
            send_valid_q <= (state_next == SEND);
            if (pc_load) pc_q <= bus.pc_next;
            if (r_hs) begin
                inst_q  <= r_fault ? FAULT_INST : bus.rdata;
                fault_q <= r_fault;
            end
        end
    end

`ifdef YSYX_23060059_IFU_PERF_EN
    logic fetch_stall;
    assign fetch_stall = ((state == FETCH_AR) && !ar_hs) || ((state == FETCH_R) && !r_hs);

    ifu_perf_cnt u_perf (
        .clk        (clk),
        .rst        (rst),
        .fetch_done (r_hs),
        .stall      (fetch_stall),
        .fetch_cnt  (perf_fetch_cnt),
        .stall_cnt  (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: acts as both AXI slave and decode stage.
module tb_ifu;
    import ifu_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ifu_if bus ();

`ifdef YSYX_23060059_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    ifu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
`ifdef YSYX_23060059_IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        bus.arready = 1'b0;
        bus.rdata = '0;
        bus.rresp = 2'b00;
        bus.rvalid = 1'b0;
        bus.ifu_receive_ready = 1'b0;
        bus.pc_next = '0;
        bus.pc_write_enable = 1'b0;

        // Reset values
        #12;
        check("rst_pc", bus.pc, 32'h8000_0000);
        check("rst_araddr", bus.araddr, 32'h8000_0000);
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_rready", bus.rready, 0);
        check("rst_send_valid", bus.ifu_send_valid, 0);
        check("rst_instruction", bus.instruction, 0);
        check("rst_fault", bus.fetch_fault, 0);
`ifdef YSYX_23060059_IFU_PERF_EN
        check("rst_perf_fetch", perf_fetch_cnt, 0);
        check("rst_perf_stall", perf_stall_cnt, 0);
`endif

        // 1: first fetch, zero-wait memory
        bus.arready = 1'b1;
        rst = 1'b1;
        tick();
        check("t1_arvalid", bus.arvalid, 1);
        check("t1_araddr", bus.araddr, 32'h8000_0000);
        tick();
        check("t1_arvalid_drop", bus.arvalid, 0);
        check("t1_rready", bus.rready, 1);
        bus.arready = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata = 32'h0000_0413;
        tick();
        check("t1_send_valid", bus.ifu_send_valid, 1);
        check("t1_instruction", bus.instruction, 32'h0000_0413);
        check("t1_pc", bus.pc, 32'h8000_0000);
        check("t1_fault", bus.fetch_fault, 0);
        check("t1_rready_drop", bus.rready, 0);
        bus.rvalid = 1'b0;
        bus.ifu_receive_ready = 1'b1;
        tick();
        check("t1_send_drop", bus.ifu_send_valid, 0);
        bus.ifu_receive_ready = 1'b0;

        // 2: wait for pc_next without fetching
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_no_arvalid", bus.arvalid, 0);
        end
        bus.pc_next = 32'h8000_0004;
        bus.pc_write_enable = 1'b1;
        tick();
        check("t2_arvalid", bus.arvalid, 1);
        check("t2_araddr", bus.araddr, 32'h8000_0004);
        bus.pc_write_enable = 1'b0;

        // 3: decode back-pressure, then accept with simultaneous pc write
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata = 32'h00a0_0093;
        tick();
        bus.rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t3_send_hold", bus.ifu_send_valid, 1);
            check("t3_inst_hold", bus.instruction, 32'h00a0_0093);
            check("t3_pc_hold", bus.pc, 32'h8000_0004);
            tick();
        end
        bus.ifu_receive_ready = 1'b1;
        bus.pc_write_enable = 1'b1;
        bus.pc_next = 32'h8000_0010;
        tick();
        bus.ifu_receive_ready = 1'b0;
        bus.pc_write_enable = 1'b0;
        check("t3_single_accept", bus.ifu_send_valid, 0);
        check("t3_direct_arvalid", bus.arvalid, 1);
        check("t3_direct_araddr", bus.araddr, 32'h8000_0010);

        // 4: error response substitutes ebreak
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        bus.rvalid = 1'b1;
        bus.rresp = 2'b10;
        bus.rdata = 32'hdead_beef;
        tick();
        bus.rvalid = 1'b0;
        bus.rresp = 2'b00;
        check("t4_send_valid", bus.ifu_send_valid, 1);
        check("t4_instruction", bus.instruction, 32'h0010_0073);
        check("t4_fault", bus.fetch_fault, 1);
        check("t4_pc", bus.pc, 32'h8000_0010);
        bus.ifu_receive_ready = 1'b1;
        tick();
        bus.ifu_receive_ready = 1'b0;

        // 5: misaligned pc, aligned address, fault reported
        bus.pc_write_enable = 1'b1;
        bus.pc_next = 32'h8000_0022;
        tick();
        bus.pc_write_enable = 1'b0;
        check("t5_arvalid", bus.arvalid, 1);
        check("t5_araddr", bus.araddr, 32'h8000_0020);
        // pc write and early rvalid in FETCH_AR are ignored
        bus.pc_write_enable = 1'b1;
        bus.pc_next = 32'h8000_0100;
        bus.rvalid = 1'b1;
        tick();
        bus.pc_write_enable = 1'b0;
        bus.rvalid = 1'b0;
        check("t5_ignore_araddr", bus.araddr, 32'h8000_0020);
        check("t5_ignore_arvalid", bus.arvalid, 1);
        check("t5_ignore_send", bus.ifu_send_valid, 0);
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata = 32'h0000_0013;
        tick();
        bus.rvalid = 1'b0;
        check("t5_send_valid", bus.ifu_send_valid, 1);
        check("t5_instruction", bus.instruction, 32'h0010_0073);
        check("t5_fault", bus.fetch_fault, 1);
        check("t5_pc", bus.pc, 32'h8000_0022);
        bus.ifu_receive_ready = 1'b1;
        bus.pc_write_enable = 1'b1;
        bus.pc_next = 32'h8000_0040;
        tick();
        bus.ifu_receive_ready = 1'b0;
        bus.pc_write_enable = 1'b0;

        // 6: reset in FETCH_R
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        check("t6_in_fetch_r", bus.rready, 1);
`ifdef YSYX_23060059_IFU_PERF_EN
        check("t6_perf_fetch", perf_fetch_cnt, 4);
`endif
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_arvalid", bus.arvalid, 0);
        check("t6_rst_rready", bus.rready, 0);
        check("t6_rst_pc", bus.pc, 32'h8000_0000);
        check("t6_rst_araddr", bus.araddr, 32'h8000_0000);
        check("t6_rst_send", bus.ifu_send_valid, 0);
        check("t6_rst_inst", bus.instruction, 0);
        check("t6_rst_fault", bus.fetch_fault, 0);
`ifdef YSYX_23060059_IFU_PERF_EN
        check("t6_rst_perf_fetch", perf_fetch_cnt, 0);
        check("t6_rst_perf_stall", perf_stall_cnt, 0);
`endif
        tick();
        rst = 1'b1;
        tick();
        check("t6_refetch_arvalid", bus.arvalid, 1);
        check("t6_refetch_araddr", bus.araddr, 32'h8000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction fetch unit; the IFU-side peer of the decode stage's fetch handshake.
- Holds the architectural PC and issues one AXI4-Lite read (AR/R channels) per instruction.
- Presents {instruction, pc} to decode with valid/ready, then waits for decode to return the next PC on pc_next/pc_write_enable before fetching again.
- Strictly one instruction in flight; no prediction.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset; first fetch address.
FAULT_INST, 32'h0010_0073, instruction word substituted on fetch fault (ebreak, halts simulation).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
araddr  out  32  read address
arvalid  out  1  read-address valid
arready  in  1  read-address ready
rdata  in  32  read data
rresp  in  2  read response, 2'b00 = OKAY
rvalid  in  1  read-data valid
rready  out  1  read-data ready
instruction  out  32  fetched instruction to decode
pc  out  32  PC of the presented instruction
ifu_send_valid  out  1  instruction/pc valid to decode
ifu_receive_ready  in  1  decode accepts (decode-side latched ready)
pc_next  in  32  next PC computed by decode
pc_write_enable  in  1  pc_next valid this cycle
fetch_fault  out  1  presented instruction is a fault substitute

Behaviour:
Reset (rst low, async), all outputs forced:
- pc=RESET_PC; araddr=RESET_PC; state=FETCH_AR.
- arvalid=0, rready=0, ifu_send_valid=0, instruction=0, fetch_fault=0.

First posedge after release: arvalid=1. No idle cycle for the reset fetch.

States:
- FETCH_AR: arvalid=1, araddr={pc[31:2],2'b00}.
  - arvalid&&arready -> FETCH_R; arvalid drops next cycle.
  - araddr/arvalid stay stable until the handshake.
- FETCH_R: rready=1.
  - On rvalid&&rready: instruction<=rdata, fetch_fault<=0.
  - If rresp!=0 or pc[1:0]!=0: instruction<=FAULT_INST, fetch_fault<=1.
  - Then -> SEND.
- SEND: ifu_send_valid=1; instruction/pc/fetch_fault held stable.
  - On ifu_send_valid&&ifu_receive_ready: ifu_send_valid<=0 next cycle; -> WAIT_PC.
  - Simultaneous pc_write_enable: pc<=pc_next, -> FETCH_AR directly.
- WAIT_PC: on pc_write_enable, pc<=pc_next, -> FETCH_AR (arvalid=1 next cycle).

Timing and edge cases:
- Minimum loop, pc_write_enable to next arvalid: 1 cycle.
- With zero-wait memory, fetch latency from arvalid to ifu_send_valid: 2 cycles.
- pc_write_enable in FETCH_AR or FETCH_R: ignored; in-flight read completes with old pc.
- pc_next is not masked; a misaligned pc is reported via fetch_fault and araddr is aligned.
- rvalid arriving while rready=0: not accepted (the AXI slave holds it).
- Reset mid-transaction: outstanding AR/R abandoned; the interconnect is reset by the same rst.

Optional Feature:
YSYX_23060059_IFU_PERF_EN
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on every R handshake.
  - perf_stall_cnt increments on every cycle in FETCH_AR or FETCH_R without the corresponding handshake.
  - Both wrap at 2^32.
- Undefined: ports and logic absent; functional behaviour identical.

Decomposition:
- Package ifu_pkg holds:
  - state enum {FETCH_AR, FETCH_R, SEND, WAIT_PC}
  - RESP_OKAY=2'b00
  - default RESET_PC and FAULT_INST constants
- One sub-module ifu_perf_cnt (the two counters), instantiated only under YSYX_23060059_IFU_PERF_EN.

Test Plan:
1. Reset release, arready=1, rvalid one cycle later with rdata=32'h00000413, rresp=0.
   -> araddr=32'h80000000; ifu_send_valid at cycle 3; instruction=32'h00000413, pc=32'h80000000, fetch_fault=0.
2. After handshake, hold pc_write_enable=0 for 5 cycles, then pulse it with pc_next=32'h80000004.
   -> no arvalid during the wait; arvalid=1 with araddr=32'h80000004 the next cycle.
3. ifu_receive_ready held low for 4 cycles.
   -> ifu_send_valid, instruction and pc stable throughout; single accept.
4. rresp=2'b10 on fetch of 32'h80000010.
   -> instruction=32'h00100073, fetch_fault=1, pc=32'h80000010.
5. pc_next=32'h80000022.
   -> araddr=32'h80000020, fetch_fault=1.
6. rst asserted low while in FETCH_R.
   -> outputs immediately at reset values; refetch from 32'h80000000 after release. With perf enabled, counters read 0.
